// File: rtl/sv_uart_pkg.sv
// Shared types and constants for the UART receive path.
// Provides the byte width and the packer FSM state encoding.
package sv_uart_pkg;

    localparam int WORD_WIDTH = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } packer_state_t;

endpackage

// File: rtl/sv_uart_rx_packer.sv
// Packs UART RX bytes MSB-first into DATA_WIDTH words with an inter-byte
// timeout that discards partial words and a 1-word output register.
// Ports:
//   iclk, irst          clock, synchronous active-low reset
//   s_axis_t*           byte stream in (tdata 8b, tvalid, tready)
//   m_axis_t*           word stream out (tdata DATA_WIDTH, tvalid, tready)
//   itimeout            inter-byte gap limit in cycles, 0 disables
//   otimeout            1-cycle pulse when a partial word is discarded
module sv_uart_rx_packer
    import sv_uart_pkg::*;
#(
    parameter int DATA_WIDTH = 24,
    parameter int TO_WIDTH   = 24
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [WORD_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic [TO_WIDTH-1:0]   itimeout,
    output logic                  otimeout
);

    localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int BCW   = $clog2(WORDS);
    localparam logic [BCW-1:0] LAST = BCW'(WORDS - 1);
    localparam logic [TO_WIDTH-1:0] TO_ONE = TO_WIDTH'(1);

    generate
        if ((DATA_WIDTH % WORD_WIDTH) != 0 || DATA_WIDTH < 16) begin : g_bad_width
            $error("sv_uart_rx_packer: DATA_WIDTH must be a multiple of 8 and >= 16");
        end
    endgenerate

    packer_state_t         state_q, state_d;
    logic [BCW-1:0]        bcnt_q;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_vld_q;
    logic [TO_WIDTH-1:0]   to_cnt_q;
    logic                  to_pulse_q;

    logic rdy, acc, last, drain, out_free, to_act, expire;

    assign asm_next = {asm_q[DATA_WIDTH-WORD_WIDTH-1:0], s_axis_tdata};

    // State register
    always_ff @(posedge iclk) begin
        if (!irst) state_q <= FILL;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL: if (last && !out_free) state_d = HOLD;
            HOLD: if (drain)             state_d = FILL;
            default:                     state_d = FILL;
        endcase
    end

    // Output / control decode
    always_comb begin
        rdy      = (state_q == FILL);
        acc      = s_axis_tvalid && rdy;
        last     = acc && (bcnt_q == LAST);
        drain    = out_vld_q && m_axis_tready;
        out_free = !out_vld_q || m_axis_tready;
        to_act   = (state_q == FILL) && (bcnt_q != '0) && (itimeout != '0);
        // >= rather than == so a limit lowered mid-word still fires
        expire   = to_act && !acc && (to_cnt_q >= itimeout - TO_ONE);
    end

    assign s_axis_tready = rdy;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_vld_q;
    assign otimeout      = to_pulse_q;

    // Datapath: assembler, byte counter, output register, timeout
    always_ff @(posedge iclk) begin
        if (!irst) begin
            bcnt_q     <= '0;
            asm_q      <= '0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
            to_cnt_q   <= '0;
            to_pulse_q <= 1'b0;
        end else begin
            to_pulse_q <= expire;

            if (acc) begin
                asm_q  <= asm_next;
                bcnt_q <= last ? '0 : bcnt_q + BCW'(1);
            end else if (expire) begin
                asm_q  <= '0;
                bcnt_q <= '0;
            end

            if (!to_act || acc || expire) to_cnt_q <= '0;
            else                          to_cnt_q <= to_cnt_q + TO_ONE;

            // A held word takes priority; no byte is accepted in HOLD
            if (state_q == HOLD && drain) begin
                out_data_q <= asm_q;
                out_vld_q  <= 1'b1;
            end else if (last && out_free) begin
                out_data_q <= asm_next;
                out_vld_q  <= 1'b1;
            end else if (drain) begin
                out_vld_q  <= 1'b0;
            end
        end
    end

endmodule
